// File: rtl/lieat_axi_pkg.sv
// Shared AXI constants, master FSM state type and response-decode helper
// for the lieat single-beat AXI master.
package lieat_axi_pkg;

  localparam int AXI_DATA_W = 64;
  localparam int AXI_STRB_W = 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RESP
  } master_state_e;

  // SLVERR/DECERR both have bit 1 set; a foreign ID means the beat is not ours.
  function automatic logic resp_is_err(input logic [1:0] resp,
                                       input logic [3:0] id,
                                       input logic [3:0] exp_id);
    return resp[1] | (id != exp_id);
  endfunction

endpackage

// File: rtl/lieat_axi_master.sv
// Single-outstanding, single-beat AXI4 master bridging a core valid/ready
// request/response port onto the io_master_* AXI channels.
module lieat_axi_master
  import lieat_axi_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2:0]            req_size,
  input  logic [AXI_DATA_W-1:0] req_wdata,
  input  logic [AXI_STRB_W-1:0] req_wstrb,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [AXI_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,

  output logic                  io_master_awvalid,
  input  logic                  io_master_awready,
  output logic [ADDR_W-1:0]     io_master_awaddr,
  output logic [3:0]            io_master_awid,
  output logic [7:0]            io_master_awlen,
  output logic [2:0]            io_master_awsize,
  output logic [1:0]            io_master_awburst,

  output logic                  io_master_wvalid,
  input  logic                  io_master_wready,
  output logic [AXI_DATA_W-1:0] io_master_wdata,
  output logic [AXI_STRB_W-1:0] io_master_wstrb,
  output logic                  io_master_wlast,

  input  logic                  io_master_bvalid,
  output logic                  io_master_bready,
  input  logic [1:0]            io_master_bresp,
  input  logic [3:0]            io_master_bid,

  output logic                  io_master_arvalid,
  input  logic                  io_master_arready,
  output logic [ADDR_W-1:0]     io_master_araddr,
  output logic [3:0]            io_master_arid,
  output logic [7:0]            io_master_arlen,
  output logic [2:0]            io_master_arsize,
  output logic [1:0]            io_master_arburst,

  input  logic                  io_master_rvalid,
  output logic                  io_master_rready,
  input  logic [AXI_DATA_W-1:0] io_master_rdata,
  input  logic [1:0]            io_master_rresp,
  input  logic                  io_master_rlast,
  input  logic [3:0]            io_master_rid
);

  master_state_e         state_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic [2:0]            size_reg;
  logic [AXI_DATA_W-1:0] wdata_reg;
  logic [AXI_STRB_W-1:0] wstrb_reg;
  logic                  req_ready_reg;
  logic                  arvalid_reg;
  logic                  rready_reg;
  logic                  awvalid_reg;
  logic                  wvalid_reg;
  logic                  bready_reg;
  logic                  aw_done_reg;
  logic                  w_done_reg;
  logic                  rsp_valid_reg;
  logic [AXI_DATA_W-1:0] rdata_reg;
  logic                  err_reg;

  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;
  logic unused_rlast;

  assign aw_hs  = awvalid_reg & io_master_awready;
  assign w_hs   = wvalid_reg & io_master_wready;
  assign aw_fin = aw_done_reg | aw_hs;
  assign w_fin  = w_done_reg | w_hs;

  // Single-beat transfers only; the fabric's slave side leaves rlast undriven.
  assign unused_rlast = io_master_rlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      size_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      req_ready_reg <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          req_ready_reg <= 1'b1;
          if (req_valid && req_ready_reg) begin
            req_ready_reg <= 1'b0;
            addr_reg      <= req_addr;
            size_reg      <= req_size;
            wdata_reg     <= req_wdata;
            wstrb_reg     <= req_wstrb;
            if (req_write) begin
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              aw_done_reg <= 1'b0;
              w_done_reg  <= 1'b0;
              state_reg   <= ST_WR_REQ;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= ST_RD_ADDR;
            end
          end
        end

        ST_RD_ADDR: begin
          if (io_master_arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (io_master_rvalid) begin
            rready_reg    <= 1'b0;
            rdata_reg     <= io_master_rdata;
            err_reg       <= resp_is_err(io_master_rresp, io_master_rid, AXI_ID);
            rsp_valid_reg <= 1'b1;
            state_reg     <= ST_RESP;
          end
        end

        // AW and W retire independently; leave once both have handshaken,
        // whether in earlier cycles or in this one.
        ST_WR_REQ: begin
          if (aw_hs) begin
            awvalid_reg <= 1'b0;
            aw_done_reg <= 1'b1;
          end
          if (w_hs) begin
            wvalid_reg <= 1'b0;
            w_done_reg <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            bready_reg  <= 1'b1;
            state_reg   <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          if (io_master_bvalid) begin
            bready_reg    <= 1'b0;
            rdata_reg     <= '0;
            err_reg       <= resp_is_err(io_master_bresp, io_master_bid, AXI_ID);
            rsp_valid_reg <= 1'b1;
            state_reg     <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

  assign io_master_awvalid = awvalid_reg;
  assign io_master_awaddr  = addr_reg;
  assign io_master_awid    = AXI_ID;
  assign io_master_awlen   = 8'h00;
  assign io_master_awsize  = size_reg;
  assign io_master_awburst = AXI_BURST_INCR;

  assign io_master_wvalid  = wvalid_reg;
  assign io_master_wdata   = wdata_reg;
  assign io_master_wstrb   = wstrb_reg;
  assign io_master_wlast   = wvalid_reg;

  assign io_master_bready  = bready_reg;

  assign io_master_arvalid = arvalid_reg;
  assign io_master_araddr  = addr_reg;
  assign io_master_arid    = AXI_ID;
  assign io_master_arlen   = 8'h00;
  assign io_master_arsize  = size_reg;
  assign io_master_arburst = AXI_BURST_INCR;

  assign io_master_rready  = rready_reg;

endmodule
